// File: rtl/merge_scheduler.sv
// merge_scheduler: packet-granular round-robin merge of lane0, lane1 and core.
// Optional watchdog: define MERGE_SCHEDULER_WATCHDOG_EN.
module merge_scheduler #(
  parameter int WIDTH   = 11,
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [1:0]            out_src,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  locked,
  output logic [15:0]           pkt_count,
  output logic                  wd_err
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t     state;
  logic [1:0] rr_ptr;
  logic [1:0] owner;
  logic       can_load;
  logic       sel_hit;
  logic [1:0] sel_idx;
  logic [1:0] idx;
  logic       xfer;
  logic       sel_last;
  logic [WIDTH-1:0] sel_data;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign can_load = !out_valid || out_ready;
  assign locked   = (state == LOCK);

  // Pick the source: owner while locked, else first valid from rr_ptr.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = 2'd0;
    idx     = rr_ptr;
    if (state == LOCK) begin
      sel_hit = req_valid[owner];
      sel_idx = owner;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!sel_hit && req_valid[idx]) begin
          sel_hit = 1'b1;
          sel_idx = idx;
        end
        idx = inc3(idx);
      end
    end
  end

  assign xfer      = can_load && sel_hit && rst_n;
  assign req_ready = xfer ? (NREQ'(1) << sel_idx) : '0;
  assign sel_last  = req_last[sel_idx];
  assign sel_data  = req_data[sel_idx*WIDTH +: WIDTH];

`ifdef MERGE_SCHEDULER_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt;
`else
  assign wd_err = 1'b0;
`endif

  // Output register, packet lock FSM, round-robin pointer and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      owner     <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      out_last  <= 1'b0;
      pkt_count <= 16'd0;
`ifdef MERGE_SCHEDULER_WATCHDOG_EN
      wd_err    <= 1'b0;
      wd_cnt    <= '0;
`endif
    end else begin
`ifdef MERGE_SCHEDULER_WATCHDOG_EN
      wd_err <= 1'b0;
`endif
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_src   <= sel_idx;
        out_last  <= sel_last;
`ifdef MERGE_SCHEDULER_WATCHDOG_EN
        wd_cnt    <= '0;
`endif
        if (sel_last) begin
          state     <= IDLE;
          pkt_count <= pkt_count + 16'd1;
          rr_ptr    <= inc3(sel_idx);
        end else if (state == IDLE) begin
          state <= LOCK;
          owner <= sel_idx;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef MERGE_SCHEDULER_WATCHDOG_EN
      if (state == LOCK && !req_valid[owner]) begin
        if (wd_cnt == WDW'(TIMEOUT - 1)) begin
          wd_err <= 1'b1;
          wd_cnt <= '0;
          state  <= IDLE;
          rr_ptr <= inc3(owner);
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_merge_scheduler.sv
// tb_merge_scheduler: directed vector table plus multi-cycle corner sequences.
module tb_merge_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_last;
  logic [32:0] req_data;
  logic [2:0]  req_ready;
  logic        out_valid;
  logic [10:0] out_data;
  logic [1:0]  out_src;
  logic        out_last;
  logic        out_ready;
  logic        locked;
  logic [15:0] pkt_count;
  logic        wd_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  merge_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_last(out_last),
    .out_ready(out_ready), .locked(locked),
    .pkt_count(pkt_count), .wd_err(wd_err)
  );

  typedef struct {
    logic [2:0]  v;
    logic [2:0]  l;
    logic        ord;
    logic [10:0] d1;
    logic [2:0]  er;
    logic        ev;
    logic        el;
    logic        lk;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(
    logic [2:0] v, logic [2:0] l, logic ord, logic [10:0] d1,
    logic [2:0] er, logic ev, logic el, logic lk, logic [15:0] cnt);
    vec_t r;
    r.v = v; r.l = l; r.ord = ord; r.d1 = d1; r.er = er;
    r.ev = ev; r.el = el; r.lk = lk; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] l,
                       input logic [10:0] d0, input logic [10:0] d1,
                       input logic [10:0] d2);
    req_valid = v;
    req_last  = l;
    req_data  = {d2, d1, d0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [10:0] d0, d2, ed;
    logic [1:0]  es;
    int n;
    int guard;

    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(3'b000, 3'b000, 11'h0, 11'h0, 11'h0);
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_locked", locked, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_wd_err", wd_err, 0);
    drive(3'b111, 3'b111, 11'h1, 11'h2, 11'h3);
    #1;
    chk("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;

    // single-flit round robin
    vt[0]  = mk(3'b111, 3'b111, 1, 11'h020, 3'b001, 1, 1, 0, 1);
    vt[1]  = mk(3'b111, 3'b111, 1, 11'h020, 3'b010, 1, 1, 0, 2);
    vt[2]  = mk(3'b111, 3'b111, 1, 11'h020, 3'b100, 1, 1, 0, 3);
    vt[3]  = mk(3'b111, 3'b111, 1, 11'h020, 3'b001, 1, 1, 0, 4);
    vt[4]  = mk(3'b111, 3'b111, 1, 11'h020, 3'b010, 1, 1, 0, 5);
    vt[5]  = mk(3'b111, 3'b111, 1, 11'h020, 3'b100, 1, 1, 0, 6);
    // lane1 4-flit packet, then core
    vt[6]  = mk(3'b110, 3'b101, 1, 11'h101, 3'b010, 1, 0, 1, 6);
    vt[7]  = mk(3'b111, 3'b101, 1, 11'h102, 3'b010, 1, 0, 1, 6);
    vt[8]  = mk(3'b111, 3'b101, 1, 11'h103, 3'b010, 1, 0, 1, 6);
    vt[9]  = mk(3'b111, 3'b111, 1, 11'h104, 3'b010, 1, 1, 0, 7);
    vt[10] = mk(3'b101, 3'b101, 1, 11'h020, 3'b100, 1, 1, 0, 8);
    // backpressure for 5 cycles, then resume
    for (int i = 11; i < 16; i++)
      vt[i] = mk(3'b111, 3'b111, 0, 11'h020, 3'b000, 1, 1, 0, 8);
    vt[16] = mk(3'b111, 3'b111, 1, 11'h020, 3'b001, 1, 1, 0, 9);
    vt[17] = mk(3'b000, 3'b000, 1, 11'h020, 3'b000, 0, 0, 0, 9);

    ed = '0;
    es = '0;
    for (int i = 0; i < 18; i++) begin
      d0 = 11'h010 + 11'(i);
      d2 = 11'h030 + 11'(i);
      drive(vt[i].v, vt[i].l, d0, vt[i].d1, d2);
      out_ready = vt[i].ord;
      #1;
      chk($sformatf("v%0d_ready", i), req_ready, vt[i].er);
      if (vt[i].er == 3'b001) begin ed = d0; es = 2'd0; end
      if (vt[i].er == 3'b010) begin ed = vt[i].d1; es = 2'd1; end
      if (vt[i].er == 3'b100) begin ed = d2; es = 2'd2; end
      step();
      chk($sformatf("v%0d_valid", i), out_valid, vt[i].ev);
      if (vt[i].ev) begin
        chk($sformatf("v%0d_data", i), out_data, ed);
        chk($sformatf("v%0d_src", i), out_src, es);
        chk($sformatf("v%0d_last", i), out_last, vt[i].el);
      end
      chk($sformatf("v%0d_locked", i), locked, vt[i].lk);
      chk($sformatf("v%0d_cnt", i), pkt_count, vt[i].cnt);
    end

    // reset mid-packet: core owns, 2 of 3 flits sent (rr_ptr = 1)
    out_ready = 1'b1;
    drive(3'b100, 3'b000, 11'h0, 11'h0, 11'h201);
    #1;
    chk("mid_grant_core", req_ready, 3'b100);
    step();
    drive(3'b101, 3'b000, 11'h0, 11'h0, 11'h202);
    step();
    chk("mid_locked", locked, 1);
    chk("mid_src", out_src, 2);
    rst_n = 1'b0;
    drive(3'b111, 3'b111, 11'h055, 11'h066, 11'h203);
    #1;
    chk("mid_rst_ready", req_ready, 0);
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_cnt", pkt_count, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_lane0_first", req_ready, 3'b001);
    step();
    chk("mid_lane0_data", out_data, 11'h055);

    // watchdog: lane0 locks then goes idle (rr_ptr = 1 now)
    drive(3'b001, 3'b000, 11'h077, 11'h0, 11'h0);
    #1;
    chk("wd_lock_grant", req_ready, 3'b001);
    step();
    chk("wd_locked", locked, 1);
    drive(3'b000, 3'b000, 11'h0, 11'h0, 11'h0);
`ifdef MERGE_SCHEDULER_WATCHDOG_EN
    n = 0;
    for (int k = 1; k <= 64; k++) begin
      step();
      if (wd_err !== (k == 64)) n++;
    end
    chk("wd_pulse_timing", n, 0);
    chk("wd_unlocked", locked, 0);
    chk("wd_cnt_same", pkt_count, 1);
    step();
    chk("wd_pulse_single", wd_err, 0);
    drive(3'b111, 3'b111, 11'h1, 11'h2, 11'h3);
    #1;
    chk("wd_lane1_next", req_ready, 3'b010);
    step();
`else
    n = 0;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (wd_err !== 1'b0 || locked !== 1'b1) n++;
    end
    chk("nowd_hold", n, 0);
    drive(3'b111, 3'b111, 11'h1, 11'h2, 11'h3);
    #1;
    chk("nowd_owner_only", req_ready, 3'b001);
    step();
    chk("nowd_release", locked, 0);
`endif

    // pkt_count wrap
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(3'b001, 3'b001, 11'h5, 11'h0, 11'h0);
    n = 0;
    guard = 0;
    while (n < 65535 && guard < 70000) begin
      #1;
      if (req_ready[0]) n++;
      step();
      guard++;
    end
    chk("wrap_ffff", pkt_count, 16'hFFFF);
    #1;
    chk("wrap_ready", req_ready, 3'b001);
    step();
    chk("wrap_zero", pkt_count, 16'h0000);
    drive(3'b000, 3'b000, 11'h0, 11'h0, 11'h0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
